// File: rtl/logic_op_arbiter.sv
// rtl/logic_op_arbiter.sv - round-robin arbiter sharing one bitwise logic unit among four requesters
// Each operation runs IDLE -> BUSY -> DONE, giving one completion every three cycles.
module logic_op_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [3:0]         req,
    input  logic [11:0]        op_flat,
    input  logic [4*WIDTH-1:0] a_flat,
    input  logic [4*WIDTH-1:0] b_flat,
    output logic [3:0]         grant,
    output logic [3:0]         ack,
    output logic [WIDTH-1:0]   result,
    output logic               result_valid,
    output logic [1:0]         result_id,
    output logic               result_err,
    output logic               busy,
    output logic [15:0]        ops_done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [1:0]       r_rr_ptr;
    logic [1:0]       r_win;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [3:0]       r_grant;
    logic [3:0]       r_ack;
    logic [WIDTH-1:0] r_result;
    logic             r_result_valid;
    logic [1:0]       r_result_id;
    logic             r_result_err;
    logic [15:0]      r_ops_done;

    logic [6:0]       w_req_dbl;
    logic [3:0]       w_req_rot;
    logic [1:0]       w_offset;
    logic [1:0]       w_winner;
    logic [3:0]       w_winner_oh;
    logic [2:0]       w_op_arr [4];
    logic [WIDTH-1:0] w_a_arr  [4];
    logic [WIDTH-1:0] w_b_arr  [4];
    logic [WIDTH-1:0] w_alu;
    logic             w_alu_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (|req) w_next = S_BUSY;
            S_BUSY:  w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Rotate requests so that bit 0 is the requester at rr_ptr, then take the first set bit.
    always_comb begin
        w_req_dbl = {req[2:0], req};
        w_req_rot = w_req_dbl[r_rr_ptr +: 4];
        if (w_req_rot[0])      w_offset = 2'd0;
        else if (w_req_rot[1]) w_offset = 2'd1;
        else if (w_req_rot[2]) w_offset = 2'd2;
        else                   w_offset = 2'd3;
        w_winner    = r_rr_ptr + w_offset;
        w_winner_oh = 4'b0001 << w_winner;
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_op_arr[i] = op_flat[3*i +: 3];
            w_a_arr[i]  = a_flat[WIDTH*i +: WIDTH];
            w_b_arr[i]  = b_flat[WIDTH*i +: WIDTH];
        end
    end

    always_comb begin
        w_alu     = '0;
        w_alu_err = 1'b0;
        case (r_op)
            3'd0: w_alu = ~r_a;
            3'd1: w_alu = r_a | r_b;
            3'd2: w_alu = r_a & r_b;
            3'd3: w_alu = r_a ^ r_b;
            3'd4: w_alu = ~(r_a ^ r_b);
            3'd5: w_alu = ~(r_a | r_b);
            3'd6: w_alu = ~(r_a & r_b);
            default: begin
                w_alu     = '0;
                w_alu_err = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr       <= 2'd0;
            r_win          <= 2'd0;
            r_op           <= 3'd0;
            r_a            <= '0;
            r_b            <= '0;
            r_grant        <= 4'd0;
            r_ack          <= 4'd0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
            r_result_id    <= 2'd0;
            r_result_err   <= 1'b0;
            r_ops_done     <= 16'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (|req) begin
                        r_grant <= w_winner_oh;
                        r_win   <= w_winner;
                        r_op    <= w_op_arr[w_winner];
                        r_a     <= w_a_arr[w_winner];
                        r_b     <= w_b_arr[w_winner];
                    end
                end
                S_BUSY: begin
                    r_result       <= w_alu;
                    r_result_valid <= 1'b1;
                    r_ack          <= r_grant;
                    r_result_id    <= r_win;
                    r_result_err   <= w_alu_err;
                end
                S_DONE: begin
                    r_result_valid <= 1'b0;
                    r_ack          <= 4'd0;
                    r_grant        <= 4'd0;
                    r_result_id    <= 2'd0;
                    r_result_err   <= 1'b0;
                    r_rr_ptr       <= r_win + 2'd1;
                    if (r_ops_done != 16'hFFFF) begin
                        r_ops_done <= r_ops_done + 16'd1;
                    end
                end
                default: begin
                    r_grant <= 4'd0;
                    r_ack   <= 4'd0;
                end
            endcase
        end
    end

    assign grant        = r_grant;
    assign ack          = r_ack;
    assign result       = r_result;
    assign result_valid = r_result_valid;
    assign result_id    = r_result_id;
    assign result_err   = r_result_err;
    assign busy         = (r_state != S_IDLE);
    assign ops_done     = r_ops_done;

endmodule

// File: tb/tb_logic_op_arbiter.sv
// tb/tb_logic_op_arbiter.sv - self-checking bench for logic_op_arbiter
module tb_logic_op_arbiter;
    localparam int WIDTH = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [11:0] op_flat;
    logic [31:0] a_flat;
    logic [31:0] b_flat;
    logic [3:0]  grant;
    logic [3:0]  ack;
    logic [7:0]  result;
    logic        result_valid;
    logic [1:0]  result_id;
    logic        result_err;
    logic        busy;
    logic [15:0] ops_done;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [1:0]  m_ptr;
    logic [15:0] m_ops;

    always #5 clk = ~clk;

    logic_op_arbiter #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .op_flat(op_flat),
        .a_flat(a_flat), .b_flat(b_flat), .grant(grant), .ack(ack),
        .result(result), .result_valid(result_valid), .result_id(result_id),
        .result_err(result_err), .busy(busy), .ops_done(ops_done)
    );

    function automatic logic [7:0] ref_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'd0: return ~a;
            3'd1: return a | b;
            3'd2: return a & b;
            3'd3: return a ^ b;
            3'd4: return ~(a ^ b);
            3'd5: return ~(a | b);
            3'd6: return ~(a & b);
            default: return 8'h00;
        endcase
    endfunction

    function automatic int ref_winner(input logic [3:0] rq, input logic [1:0] ptr);
        for (int k = 0; k < 4; k++) begin
            if (rq[(int'(ptr) + k) % 4]) return (int'(ptr) + k) % 4;
        end
        return -1;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Invariants observed on every cycle outside reset.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            n_checks++;
            if ($countones(grant) > 1 || $countones(ack) > 1 || (result_valid && ack !== grant)) begin
                n_fail++;
                $display("FAIL invariant: grant=%b ack=%b result_valid=%b", grant, ack, result_valid);
            end
        end
    end

    // Waits (bounded) for a grant, then samples the completion cycle.
    task automatic step_txn(output logic [3:0] o_g, output logic o_busy, output logic o_vld0,
                            output logic o_vld1, output logic [3:0] o_ack, output logic [7:0] o_res,
                            output logic [1:0] o_id, output logic o_err, output int o_wait);
        o_g = 4'd0; o_busy = 1'b0; o_vld0 = 1'b0; o_vld1 = 1'b0;
        o_ack = 4'd0; o_res = 8'd0; o_id = 2'd0; o_err = 1'b0; o_wait = 99;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (grant != 4'd0) begin
                o_wait = c + 1;
                break;
            end
        end
        if (o_wait != 99) begin
            o_g = grant; o_busy = busy; o_vld0 = result_valid;
            @(negedge clk);
            o_vld1 = result_valid; o_ack = ack; o_res = result; o_id = result_id; o_err = result_err;
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req = 4'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_ptr = 2'd0;
        m_ops = 16'd0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++;
        if ({grant, ack, result, result_valid, result_id, result_err, busy, ops_done} !== 36'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got g=%b ack=%b res=%h v=%b id=%0d err=%b busy=%b ops=%h, want all 0",
                     grant, ack, result, result_valid, result_id, result_err, busy, ops_done);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || grant !== 4'd0 || result_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_no_req: busy=%b grant=%b valid=%b, want 0", busy, grant, result_valid);
        end
    endtask

    task automatic test_single();
        logic [3:0] g, ak; logic bz, v0, v1, er; logic [7:0] rs; logic [1:0] id; int wt;
        req = 4'b0001; op_flat = 12'd2; a_flat = 32'h000000F0; b_flat = 32'h0000003C;
        step_txn(g, bz, v0, v1, ak, rs, id, er, wt);
        n_checks++;
        if (g !== 4'b0001 || bz !== 1'b1 || v0 !== 1'b0) begin
            n_fail++;
            $display("FAIL single_grant: g=%b busy=%b v0=%b, want 0001 1 0", g, bz, v0);
        end
        n_checks++;
        if (v1 !== 1'b1 || ak !== 4'b0001 || rs !== 8'h30 || id !== 2'd0 || er !== 1'b0) begin
            n_fail++;
            $display("FAIL single_result: v=%b ack=%b res=%h id=%0d err=%b, want 1 0001 30 0 0", v1, ak, rs, id, er);
        end
        req = 4'd0;
        m_ptr = 2'd1; m_ops = sat_inc(m_ops);
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || result_valid !== 1'b0 || ack !== 4'd0 || ops_done !== m_ops || result !== 8'h30) begin
            n_fail++;
            $display("FAIL single_done: busy=%b v=%b ack=%b ops=%h res=%h, want 0 0 0000 %h 30",
                     busy, result_valid, ack, ops_done, m_ops, result);
        end
    endtask

    task automatic test_op_sweep();
        logic [7:0] exp_tab [8];
        logic [3:0] g, ak; logic bz, v0, v1, er; logic [7:0] rs; logic [1:0] id; int wt;
        exp_tab = '{8'h5A, 8'hAF, 8'h05, 8'hAA, 8'h55, 8'h50, 8'hFA, 8'h00};
        for (int op = 0; op < 8; op++) begin
            req = 4'b0100;
            op_flat = 12'd0; op_flat[8:6] = 3'(op);
            a_flat = $urandom; a_flat[23:16] = 8'hA5;
            b_flat = $urandom; b_flat[23:16] = 8'h0F;
            step_txn(g, bz, v0, v1, ak, rs, id, er, wt);
            n_checks++;
            if (rs !== exp_tab[op] || er !== (op == 7) || id !== 2'd2 || ak !== 4'b0100 || v1 !== 1'b1) begin
                n_fail++;
                $display("FAIL sweep_op%0d: res=%h err=%b id=%0d ack=%b v=%b, want %h %b 2 0100 1",
                         op, rs, er, id, ak, v1, exp_tab[op], (op == 7));
            end
            req = 4'd0;
            m_ptr = 2'd3; m_ops = sat_inc(m_ops);
            @(negedge clk);
            n_checks++;
            if (ops_done !== m_ops || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL sweep_ops_done%0d: ops=%h busy=%b, want %h 0", op, ops_done, busy, m_ops);
            end
        end
    endtask

    task automatic test_fairness();
        int order [5];
        logic [3:0] g, ak; logic bz, v0, v1, er; logic [7:0] rs; logic [1:0] id; int wt, w;
        order = '{0, 1, 2, 3, 0};
        apply_reset();
        req = 4'b1111; op_flat = $urandom; a_flat = $urandom; b_flat = $urandom;
        for (int t = 0; t < 5; t++) begin
            step_txn(g, bz, v0, v1, ak, rs, id, er, wt);
            w = ref_winner(4'b1111, m_ptr);
            n_checks++;
            if (g !== (4'b0001 << order[t]) || w != order[t] || id !== 2'(order[t])) begin
                n_fail++;
                $display("FAIL fair_order%0d: grant=%b id=%0d, want index %0d", t, g, id, order[t]);
            end
            n_checks++;
            if (wt != ((t == 0) ? 1 : 2)) begin
                n_fail++;
                $display("FAIL fair_throughput%0d: wait=%0d, want %0d", t, wt, (t == 0) ? 1 : 2);
            end
            n_checks++;
            if (rs !== ref_op(op_flat[3*w +: 3], a_flat[8*w +: 8], b_flat[8*w +: 8])) begin
                n_fail++;
                $display("FAIL fair_result%0d: res=%h, want %h", t, rs,
                         ref_op(op_flat[3*w +: 3], a_flat[8*w +: 8], b_flat[8*w +: 8]));
            end
            m_ptr = 2'(w + 1); m_ops = sat_inc(m_ops);
        end
        req = 4'd0;
        @(negedge clk);
        n_checks++;
        if (ops_done !== m_ops) begin
            n_fail++;
            $display("FAIL fair_ops_done: ops=%h, want %h", ops_done, m_ops);
        end
    endtask

    task automatic test_operand_stability();
        logic [7:0] a0, b0;
        logic [3:0] g, ak; logic bz, v0, v1, er; logic [7:0] rs; logic [1:0] id; int wt, w;
        a0 = 8'($urandom); b0 = 8'($urandom);
        req = 4'b0010; op_flat = 12'd0; op_flat[5:3] = 3'd3;
        a_flat = 32'd0; a_flat[15:8] = a0; b_flat = 32'd0; b_flat[15:8] = b0;
        @(negedge clk);
        n_checks++;
        if (grant !== 4'b0010 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL stab_grant: grant=%b busy=%b, want 0010 1", grant, busy);
        end
        a_flat[15:8] = ~a0; b_flat[15:8] = a0; op_flat[5:3] = 3'd7;
        req = 4'b1011;
        @(negedge clk);
        n_checks++;
        if (result !== (a0 ^ b0) || result_err !== 1'b0 || result_id !== 2'd1 || result_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL stab_result: res=%h err=%b id=%0d v=%b, want %h 0 1 1",
                     result, result_err, result_id, result_valid, a0 ^ b0);
        end
        req = 4'b1001;
        m_ptr = 2'd2; m_ops = sat_inc(m_ops);
        step_txn(g, bz, v0, v1, ak, rs, id, er, wt);
        w = ref_winner(4'b1001, m_ptr);
        n_checks++;
        if (g !== (4'b0001 << w) || wt != 2) begin
            n_fail++;
            $display("FAIL held_off_req: grant=%b wait=%0d, want index %0d wait 2", g, wt, w);
        end
        req = 4'd0;
        m_ptr = 2'(w + 1); m_ops = sat_inc(m_ops);
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [3:0] g, ak; logic bz, v0, v1, er; logic [7:0] rs; logic [1:0] id; int wt, w;
        logic [2:0] e_op; logic [7:0] e_a, e_b;
        bit b2b;
        req = 4'($urandom_range(1, 15)); op_flat = $urandom; a_flat = $urandom; b_flat = $urandom;
        for (int t = 0; t < 40; t++) begin
            b2b = (t % 2) == 1;
            w = ref_winner(req, m_ptr);
            e_op = op_flat[3*w +: 3]; e_a = a_flat[8*w +: 8]; e_b = b_flat[8*w +: 8];
            step_txn(g, bz, v0, v1, ak, rs, id, er, wt);
            n_checks++;
            if (g !== (4'b0001 << w) || ak !== g || id !== 2'(w) || v1 !== 1'b1
                || rs !== ref_op(e_op, e_a, e_b) || er !== (e_op == 3'd7)) begin
                n_fail++;
                $display("FAIL rand%0d: grant=%b ack=%b id=%0d res=%h err=%b, want idx %0d res %h err %b",
                         t, g, ak, id, rs, er, w, ref_op(e_op, e_a, e_b), (e_op == 3'd7));
            end
            m_ptr = 2'(w + 1); m_ops = sat_inc(m_ops);
            if (b2b) begin
                req = 4'($urandom_range(1, 15)); op_flat = $urandom; a_flat = $urandom; b_flat = $urandom;
            end else begin
                req = 4'd0;
                @(negedge clk);
                n_checks++;
                if (ops_done !== m_ops || busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rand_ops%0d: ops=%h busy=%b, want %h 0", t, ops_done, busy, m_ops);
                end
                req = 4'($urandom_range(1, 15)); op_flat = $urandom; a_flat = $urandom; b_flat = $urandom;
            end
        end
        req = 4'd0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid_op();
        logic [3:0] g, ak; logic bz, v0, v1, er; logic [7:0] rs; logic [1:0] id; int wt;
        req = 4'b0100; op_flat = $urandom; a_flat = $urandom; b_flat = $urandom;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_pre_busy: busy=%b, want 1", busy);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({grant, ack, result, result_valid, result_id, result_err, busy, ops_done} !== 36'd0) begin
            n_fail++;
            $display("FAIL rst_async: g=%b ack=%b res=%h v=%b busy=%b ops=%h, want all 0",
                     grant, ack, result, result_valid, busy, ops_done);
        end
        req = 4'b1010;
        @(negedge clk);
        n_checks++;
        if (ack !== 4'd0 || result_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_no_ack: ack=%b v=%b, want 0", ack, result_valid);
        end
        rst_n = 1'b1;
        m_ptr = 2'd0; m_ops = 16'd0;
        step_txn(g, bz, v0, v1, ak, rs, id, er, wt);
        n_checks++;
        if (g !== 4'b0010 || ak !== 4'b0010 || id !== 2'd1) begin
            n_fail++;
            $display("FAIL rst_first_grant: grant=%b ack=%b id=%0d, want 0010 0010 1", g, ak, id);
        end
        req = 4'd0;
        m_ptr = 2'd2; m_ops = sat_inc(m_ops);
        @(negedge clk);
        n_checks++;
        if (ops_done !== m_ops) begin
            n_fail++;
            $display("FAIL rst_ops_done: ops=%h, want %h", ops_done, m_ops);
        end
    endtask

    task automatic test_saturation();
        logic [3:0] g, ak; logic bz, v0, v1, er; logic [7:0] rs; logic [1:0] id; int wt;
        force dut.r_ops_done = 16'hFFFE;
        #1;
        release dut.r_ops_done;
        m_ops = 16'hFFFE;
        for (int t = 0; t < 3; t++) begin
            req = 4'b1000; op_flat = $urandom; a_flat = $urandom; b_flat = $urandom;
            step_txn(g, bz, v0, v1, ak, rs, id, er, wt);
            req = 4'd0;
            m_ops = sat_inc(m_ops);
            @(negedge clk);
            n_checks++;
            if (ops_done !== m_ops) begin
                n_fail++;
                $display("FAIL sat%0d: ops=%h, want %h", t, ops_done, m_ops);
            end
        end
        repeat (4) @(negedge clk);
        n_checks++;
        if (ops_done !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL sat_hold: ops=%h, want ffff", ops_done);
        end
    endtask

    initial begin
        rst_n = 1'b0; req = 4'd0; op_flat = 12'd0; a_flat = 32'd0; b_flat = 32'd0;
        m_ptr = 2'd0; m_ops = 16'd0;
        test_reset();
        test_single();
        test_op_sweep();
        test_fairness();
        test_operand_stability();
        test_random();
        test_reset_mid_op();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/logic_op_arbiter.md
LOGIC_OP_ARBITER -- requirements
Module: logic_op_arbiter

Interface
REQ-001 Parameter WIDTH, default 8: operand and result width in bits; requester count is fixed at 4.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req  input  4  per-requester request; bit i belongs to requester i.
REQ-005 op_flat  input  12  per-requester opcode; requester i uses bits [3i+2:3i].
REQ-006 a_flat  input  4*WIDTH  per-requester operand A; requester i uses slice [WIDTH*i +: WIDTH].
REQ-007 b_flat  input  4*WIDTH  per-requester operand B; same slicing as a_flat.
REQ-008 grant  output  4  one-hot owner of the shared logic unit; 0 when idle.
REQ-009 ack  output  4  one-hot completion pulse to the granted requester.
REQ-010 result  output  WIDTH  registered logic-unit result.
REQ-011 result_valid  output  1  one-cycle pulse qualifying result, result_id and result_err.
REQ-012 result_id  output  2  index of the requester that owns result.
REQ-013 result_err  output  1  set with result_valid when the opcode was illegal.
REQ-014 busy  output  1  high whenever the state is not IDLE.
REQ-015 ops_done  output  16  count of completed operations; saturates at 16'hFFFF.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, BUSY and DONE.
REQ-017 In IDLE with req==0, the block SHALL remain in IDLE with all outputs except result and ops_done at 0.
REQ-018 In IDLE with req!=0 at edge N, the block SHALL select a winner round-robin, starting at index rr_ptr and searching upward modulo 4.
REQ-019 At edge N the block SHALL load grant with the winner's one-hot value, capture the winner's op, A and B into internal registers, and enter BUSY.
REQ-020 At edge N+1 the block SHALL load result from the captured operands, set result_valid=1, set ack=grant, set result_id=winner index, and enter DONE.
REQ-021 At edge N+2 the block SHALL clear result_valid, ack and grant, set rr_ptr=(winner+1) mod 4, increment ops_done unless it is saturated, and enter IDLE.
REQ-022 result SHALL hold its value until the next completion.
REQ-023 Opcode encoding: 0 NOT A; 1 A|B; 2 A&B; 3 A^B; 4 ~(A^B); 5 ~(A|B); 6 ~(A&B); all operations are bitwise over WIDTH bits.
REQ-024 Opcode 7 is illegal: result=0 and result_err=1; the operation still completes, and ack and ops_done update normally.
REQ-025 Operands and opcode are captured only at edge N; changes to req, op_flat, a_flat or b_flat during BUSY or DONE SHALL NOT affect the current operation.
REQ-026 Requests arriving during BUSY or DONE SHALL be held off and not lost; they are arbitrated at the next IDLE edge if req is still high.
REQ-027 Handshake: a requester holds req and its operands stable until it sees ack, then deasserts req within one cycle; a req still high at the next IDLE edge counts as a new request.
REQ-028 Back-to-back throughput SHALL be one operation per 3 cycles; no idle cycle is inserted when req!=0 at the IDLE edge.
REQ-029 grant and ack SHALL never have more than one bit set.
REQ-030 ack SHALL equal grant whenever result_valid=1.

Reset
REQ-031 When rst_n=0, the block SHALL immediately, without waiting for clk, set state=IDLE, rr_ptr=0, and grant, ack, result, result_valid, result_id, result_err, busy and ops_done all to 0.
REQ-032 Reset asserted during BUSY or DONE SHALL abort the operation: no ack, no result_valid and no ops_done increment.
REQ-033 After rst_n deasserts, the first arbitration SHALL start at index 0.

Verification
REQ-034 Single request: WIDTH=8, req=4'b0001, op=2, A=8'hF0, B=8'h3C; result=8'h30, result_id=0 and result_valid one cycle at edge N+1; busy for 2 cycles.
REQ-035 Full opcode sweep on requester 2 with A=8'hA5, B=8'h0F, expected results:
- op 0: 8'h5A
- op 1: 8'hAF
- op 2: 8'h05
- op 3: 8'hAA
- op 4: 8'h55
- op 5: 8'h50
- op 6: 8'hFA
- op 7: 8'h00 with result_err=1
REQ-036 Fairness: req=4'b1111 held continuously; grants in order 0,1,2,3,0 with one completion per 3 cycles and no requester served twice before all are served.
REQ-037 Operand stability: change a_flat for the granted requester during BUSY; result reflects the operands captured at edge N.
REQ-038 Reset mid-operation: assert rst_n=0 in BUSY; all outputs are 0 immediately, no ack is produced, and the next grant after release goes to the lowest requesting index from 0.
REQ-039 Saturation: preload ops_done to 16'hFFFE and complete 3 operations; ops_done reads 16'hFFFF and stays there.
